// File: rtl/valid_ctrl.sv
// valid_ctrl: single-port arbiter for the L1 valid-bit RAM (lookup reads, fill/evict RMW, flush)
module valid_ctrl #(
  parameter int NUM_WAY        = 8,
  parameter int NUM_SET        = 128,
  parameter int SET_W          = 7,
  parameter bit FLUSH_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_req,
  input  logic [SET_W-1:0]   lookup_set,
  output logic               lookup_rdy,
  output logic               lookup_vld,
  output logic [NUM_WAY-1:0] lookup_valid,
  input  logic               fill_req,
  input  logic [SET_W-1:0]   fill_set,
  input  logic [NUM_WAY-1:0] fill_way,
  input  logic               fill_val,
  output logic               fill_ack,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               mem_en,
  output logic               rd_wr,
  output logic [31:0]        mem_addr,
  output logic [NUM_WAY-1:0] mem_wdata,
  input  logic [NUM_WAY-1:0] mem_rdata
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL_RD = 2'd1;
  localparam logic [1:0] FILL_WR = 2'd2;
  localparam logic [1:0] FLUSH   = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d, addr_set;
  logic             pending_q, pending_d, lvld_q, done_q;
  logic             idle, flush_now, last, fill_rd, wr;
  // Port arbitration, RAM command generation and next-state logic
  always_comb begin
    idle      = state_q == IDLE;
    flush_now = pending_q | flush_req;
    last      = (state_q == FLUSH) && (cnt_q == SET_W'(NUM_SET - 1));
    lookup_rdy = idle & lookup_req & ~flush_now & ~fill_req;
    fill_rd   = (idle & ~flush_now & fill_req) | (state_q == FILL_RD);
    wr        = (state_q == FILL_WR) | (state_q == FLUSH);
    fill_ack  = state_q == FILL_WR;
    mem_en    = fill_rd | lookup_rdy | wr;
    rd_wr     = wr;
    addr_set  = (fill_rd | fill_ack) ? fill_set :
                lookup_rdy ? lookup_set :
                (state_q == FLUSH) ? cnt_q : '0;
    mem_addr  = {{(32-SET_W){1'b0}}, addr_set};
    mem_wdata = fill_ack ? (fill_val ? (mem_rdata | fill_way) : (mem_rdata & ~fill_way)) : '0;
    state_d   = idle ? (flush_now ? FLUSH : fill_req ? FILL_WR : IDLE) :
                (state_q == FLUSH) ? (last ? IDLE : FLUSH) :
                (state_q == FILL_RD) ? FILL_WR : IDLE;
    cnt_d     = (state_q == FLUSH) ? cnt_q + 1'b1 : cnt_q;
    pending_d = (state_q == FLUSH) ? (pending_q & ~last) : flush_now;
  end
  assign lookup_vld   = lvld_q;
  assign lookup_valid = lvld_q ? mem_rdata : '0;
  assign flush_busy   = pending_q | (state_q == FLUSH);
  assign flush_done   = done_q;
  // State, flush counter, pending flush and one-cycle response flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= FLUSH_ON_RESET;
      lvld_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      lvld_q    <= lookup_rdy;
      done_q    <= last;
    end
  end
endmodule

// File: tb/tb_valid_ctrl.sv
// tb_valid_ctrl: vector table plus scoreboard bench for valid_ctrl with a behavioural valid RAM
module tb_valid_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lookup_req = 1'b0, fill_req = 1'b0, fill_val = 1'b0, flush_req = 1'b0;
  logic [6:0]  lookup_set = '0, fill_set = '0;
  logic [7:0]  fill_way = '0;
  logic        lookup_rdy, lookup_vld, fill_ack, flush_busy, flush_done, mem_en, rd_wr;
  logic [7:0]  lookup_valid, mem_wdata, mem_rdata;
  logic [31:0] mem_addr;
  logic [7:0]  ram [128];
  logic [7:0]  exp_q [$];
  int          errs = 0, checks = 0, npush = 0, nvld = 0;

  typedef struct {
    logic [6:0] s;
    logic [7:0] w;
    logic       v;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [13];

  valid_ctrl dut (
    .clk(clk), .rst(rst),
    .lookup_req(lookup_req), .lookup_set(lookup_set), .lookup_rdy(lookup_rdy),
    .lookup_vld(lookup_vld), .lookup_valid(lookup_valid),
    .fill_req(fill_req), .fill_set(fill_set), .fill_way(fill_way), .fill_val(fill_val),
    .fill_ack(fill_ack),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .mem_en(mem_en), .rd_wr(rd_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && rd_wr) ram[mem_addr[6:0]] <= mem_wdata;
    else if (mem_en) mem_rdata <= ram[mem_addr[6:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (lookup_vld) begin
      nvld++;
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL lookup_unexpected: got vld with data %0h expected no response", lookup_valid);
      end else chk("lookup_valid", {24'b0, lookup_valid}, {24'b0, exp_q.pop_front()});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [6:0] s, input logic [7:0] w, input logic v,
                         input logic [7:0] exp, input string nm);
    fill_req = 1'b1; fill_set = s; fill_way = w; fill_val = v;
    @(negedge clk);
    chk({nm, "_rd_cmd"}, {29'b0, mem_en, rd_wr, fill_ack}, 32'b100);
    chk({nm, "_rd_addr"}, mem_addr, {25'b0, s});
    @(negedge clk);
    chk({nm, "_ack"}, {30'b0, fill_ack, rd_wr}, 32'b11);
    chk({nm, "_wdata"}, {24'b0, mem_wdata}, {24'b0, exp});
    chk({nm, "_wr_addr"}, mem_addr, {25'b0, s});
    step();
    fill_req = 1'b0;
  endtask

  task automatic do_lookup(input logic [6:0] s, input logic [7:0] exp, input string nm);
    lookup_req = 1'b1; lookup_set = s;
    @(negedge clk);
    chk({nm, "_rdy"}, {29'b0, lookup_rdy, mem_en, rd_wr}, 32'b110);
    chk({nm, "_addr"}, mem_addr, {25'b0, s});
    exp_q.push_back(exp);
    npush++;
    step();
    lookup_req = 1'b0;
  endtask

  task automatic watch(input int lim, input int pulse_at, output int nwr, output int first_done,
                       output int ndone, output int bad, output logic busy_done, output logic busy_pre);
    logic prev;
    nwr = 0; first_done = -1; ndone = 0; bad = 0; busy_done = 1'b1; busy_pre = 1'b0; prev = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (mem_en && rd_wr) begin
        if (mem_addr !== 32'(nwr) || mem_wdata !== 8'h00) bad++;
        nwr++;
      end
      if (flush_done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = c;
          busy_done = flush_busy;
          busy_pre = prev;
        end
      end
      prev = flush_busy;
      flush_req = (c == pulse_at);
    end
    flush_req = 1'b0;
  endtask

  task automatic check_flush(input string nm, input int lim, input int pulse_at);
    int nwr, fd, nd, bad;
    logic bd, bp;
    watch(lim, pulse_at, nwr, fd, nd, bad, bd, bp);
    chk({nm, "_writes"}, 32'(nwr), 32'd128);
    chk({nm, "_order"}, 32'(bad), 32'd0);
    chk({nm, "_done_cycle"}, 32'(fd), 32'd129);
    chk({nm, "_done_count"}, 32'(nd), 32'd1);
    chk({nm, "_busy_at_done"}, {31'b0, bd}, 32'd0);
    chk({nm, "_busy_before_done"}, {31'b0, bp}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int nz, nwr, found, dn;
    tv[0]  = '{7'd5,   8'h04, 1'b1, 8'h04};
    tv[1]  = '{7'd5,   8'h01, 1'b1, 8'h05};
    tv[2]  = '{7'd5,   8'h02, 1'b1, 8'h07};
    tv[3]  = '{7'd5,   8'h08, 1'b1, 8'h0F};
    tv[4]  = '{7'd5,   8'h10, 1'b1, 8'h1F};
    tv[5]  = '{7'd5,   8'h20, 1'b1, 8'h3F};
    tv[6]  = '{7'd5,   8'h40, 1'b1, 8'h7F};
    tv[7]  = '{7'd5,   8'h80, 1'b1, 8'hFF};
    tv[8]  = '{7'd5,   8'h10, 1'b0, 8'hEF};
    tv[9]  = '{7'd127, 8'h80, 1'b1, 8'h80};
    tv[10] = '{7'd0,   8'h01, 1'b1, 8'h01};
    tv[11] = '{7'd127, 8'h80, 1'b0, 8'h00};
    tv[12] = '{7'd0,   8'h01, 1'b1, 8'h01};
    for (int i = 0; i < 128; i++) ram[i] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'b0, mem_en, rd_wr, fill_ack, lookup_vld, flush_done, flush_busy}, 32'b000001);
    chk("reset_addr", mem_addr, 32'd0);
    step();
    rst = 1'b1;
    check_flush("flush_on_reset", 140, -1);
    nz = 0;
    for (int i = 0; i < 128; i++) if (ram[i] !== 8'h00) nz++;
    chk("ram_cleared", 32'(nz), 32'd0);
    step();
    for (int i = 0; i < 13; i++) begin
      do_fill(tv[i].s, tv[i].w, tv[i].v, tv[i].exp, $sformatf("vec%0d", i));
      do_lookup(tv[i].s, tv[i].exp, $sformatf("vec%0d_lk", i));
    end
    fill_req = 1'b1; fill_set = 7'd9; fill_way = 8'h02; fill_val = 1'b1;
    lookup_req = 1'b1; lookup_set = 7'd9;
    @(negedge clk);
    chk("coll_rdy_rd", {31'b0, lookup_rdy}, 32'd0);
    chk("coll_rd_addr", mem_addr, 32'd9);
    @(negedge clk);
    chk("coll_ack", {30'b0, fill_ack, lookup_rdy}, 32'b10);
    step();
    fill_req = 1'b0;
    @(negedge clk);
    chk("coll_rdy_after", {31'b0, lookup_rdy}, 32'd1);
    exp_q.push_back(8'h02);
    npush++;
    step();
    lookup_req = 1'b0;
    fill_req = 1'b1; fill_set = 7'd10; fill_way = 8'h01; fill_val = 1'b1;
    @(negedge clk);
    step();
    flush_req = 1'b1;
    @(negedge clk);
    chk("rmw_flush_ack", {31'b0, fill_ack}, 32'd1);
    chk("rmw_flush_wdata", {24'b0, mem_wdata}, 32'h01);
    step();
    flush_req = 1'b0; fill_req = 1'b0;
    chk("rmw_flush_busy", {31'b0, flush_busy}, 32'd1);
    check_flush("flush_absorb", 160, 60);
    step();
    do_lookup(7'd10, 8'h00, "after_flush_lk");
    fill_req = 1'b1; fill_set = 7'd20; fill_way = 8'h08; fill_val = 1'b1; flush_req = 1'b1;
    @(negedge clk);
    chk("flush_wins_idle", {30'b0, mem_en, fill_ack}, 32'd0);
    step();
    flush_req = 1'b0;
    nwr = 0; found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (fill_ack) begin
        found = 1;
        chk("flush_then_fill_wdata", {24'b0, mem_wdata}, 32'h08);
      end else if (mem_en && rd_wr) nwr++;
    end
    chk("flush_then_fill_acked", 32'(found), 32'd1);
    chk("flush_before_fill_writes", 32'(nwr), 32'd128);
    step();
    fill_req = 1'b0;
    do_lookup(7'd20, 8'h08, "flush_then_fill_lk");
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (mem_en && rd_wr && mem_addr == 32'd60) found = 1;
    end
    chk("reached_set60", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {26'b0, mem_en, rd_wr, fill_ack, lookup_vld, flush_done, flush_busy}, 32'b000001);
    chk("midreset_addr", mem_addr, 32'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (flush_done) dn++;
    end
    step();
    rst = 1'b1;
    check_flush("restart_flush", 140, -1);
    step();
    do_lookup(7'd5, 8'h00, "final_lk");
    repeat (2) @(negedge clk);
    chk("no_done_in_reset", 32'(dn), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("vld_count", 32'(nvld), 32'(npush));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
